// File: rtl/rfsoc_sched_pkg.sv
// Shared types and constants for the RTIO event scheduler.
//   sched_instr_t : one buffered instruction {timestamp, payload}
//   CTRL_*        : bit positions inside the ctrl_data strobe word
//   sched_state_t : issue FSM states
package rfsoc_sched_pkg;

    localparam int unsigned SCHED_TS_W      = 64;
    localparam int unsigned SCHED_PAYLOAD_W = 64;

    localparam int unsigned CTRL_RUN       = 0;
    localparam int unsigned CTRL_CLR_CNT   = 1;
    localparam int unsigned CTRL_HALT      = 2;
    localparam int unsigned CTRL_CLR_FLAGS = 3;

    typedef struct packed {
        logic [SCHED_TS_W-1:0]      ts;
        logic [SCHED_PAYLOAD_W-1:0] payload;
    } sched_instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous instruction FIFO with the head word held in a register.
//   clk, rst_n         : clock, async active-low reset
//   wr_en, wr_data     : write request; accepted only while wr_ready=1
//   wr_ready           : registered "not full"
//   rd_en              : pop the head word (ignored when empty)
//   rd_data_c          : current head word
//   empty_c            : no entries buffered
//   level              : registered number of entries buffered
module sched_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    output logic                       wr_ready,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          push;
    logic          pop;

    assign push    = wr_en && ready_q;
    assign pop     = rd_en && (level_q != '0);
    assign level_d = level_q + LW'(push) - LW'(pop);

    assign rd_data_c = mem[rd_ptr_q];
    assign empty_c   = (level_q == '0);
    assign wr_ready  = ready_q;
    assign level     = level_q;

    // Storage needs no reset: only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, level and registered ready (computed from the next level).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

endmodule

// File: rtl/rtio_event_scheduler.sv
// Timestamp-ordered event scheduler in front of the DAC sequencer.
// Buffers {timestamp, payload} instructions, owns the timeline counter and
// releases each payload in the cycle after the counter reaches its timestamp.
//   aclk, aresetn               : clock, async active-low reset
//   in_tdata/in_tvalid/in_tready: instruction stream {ts, payload}
//   ctrl_valid/ctrl_data        : strobe, [0] run [1] clear count [2] halt [3] clear flags
//   out_tdata/out_tvalid/out_tready/out_late : released payload stream
//   count, running              : timeline counter and its run state
//   fifo_level                  : entries buffered (head register excluded)
//   late_err, late_cnt          : sticky late flag and saturating late count
// Build option: SCHED_LATE_DROP_EN discards late heads instead of issuing them
// (out_late then stays 0).
module rtio_event_scheduler
    import rfsoc_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TS_W       = SCHED_TS_W,
    parameter int unsigned PAYLOAD_W  = SCHED_PAYLOAD_W,
    parameter int unsigned LATE_CNT_W = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [TS_W+PAYLOAD_W-1:0]     in_tdata,
    input  logic                          in_tvalid,
    output logic                          in_tready,
    input  logic                          ctrl_valid,
    input  logic [3:0]                    ctrl_data,
    output logic [PAYLOAD_W-1:0]          out_tdata,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic                          out_late,
    output logic [TS_W-1:0]               count,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          late_err,
    output logic [LATE_CNT_W-1:0]         late_cnt
);

    localparam int unsigned IW = TS_W + PAYLOAD_W;

    sched_state_t          state_q, state_d;
    logic [TS_W-1:0]       head_ts_q;
    logic [PAYLOAD_W-1:0]  head_pl_q;
    logic [TS_W-1:0]       count_q;
    logic                  running_q;
    logic                  valid_q, valid_d;
    logic [PAYLOAD_W-1:0]  data_q, data_d;
    logic                  late_q, late_d;
    logic                  late_err_q;
    logic [LATE_CNT_W-1:0] late_cnt_q;
    logic                  late_evt;
    logic                  fifo_pop;
    logic                  fifo_empty_c;
    logic [IW-1:0]         fifo_head_c;
    logic                  ts_hit_c;
    logic                  ts_past_c;
    logic                  do_halt_c;
    logic                  do_clr_c;
    logic                  do_run_c;

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IW)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .wr_en     (in_tvalid),
        .wr_data   (in_tdata),
        .wr_ready  (in_tready),
        .rd_en     (fifo_pop),
        .rd_data_c (fifo_head_c),
        .empty_c   (fifo_empty_c),
        .level     (fifo_level)
    );

    // One control action per strobe, highest priority wins; clear-flags is independent.
    assign do_halt_c = ctrl_valid && ctrl_data[CTRL_HALT];
    assign do_clr_c  = ctrl_valid && !ctrl_data[CTRL_HALT] && ctrl_data[CTRL_CLR_CNT];
    assign do_run_c  = ctrl_valid && !ctrl_data[CTRL_HALT] && !ctrl_data[CTRL_CLR_CNT]
                       && ctrl_data[CTRL_RUN];

    assign ts_hit_c  = (head_ts_q == count_q);
    assign ts_past_c = (head_ts_q <  count_q);

    // Next-state and output-register decode.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        late_d   = late_q;
        fifo_pop = 1'b0;
        late_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (running_q && !fifo_empty_c) begin
                    fifo_pop = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // Compare is frozen while halted.
                if (running_q && (ts_hit_c || ts_past_c)) begin
                    late_evt = ts_past_c;
`ifdef SCHED_LATE_DROP_EN
                    if (ts_past_c) begin
                        if (!fifo_empty_c) begin
                            fifo_pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = ISSUE;
                        valid_d = 1'b1;
                        data_d  = head_pl_q;
                    end
`else
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    data_d  = head_pl_q;
                    late_d  = ts_past_c;
`endif
                end
            end
            ISSUE: begin
                // Delivered regardless of halt; refill the head on the handshake.
                if (out_tready) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    late_d  = 1'b0;
                    if (!fifo_empty_c) begin
                        fifo_pop = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, head register and output stream registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            head_ts_q <= '0;
            head_pl_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            late_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            late_q  <= late_d;
            if (fifo_pop) begin
                head_ts_q <= fifo_head_c[IW-1:PAYLOAD_W];
                head_pl_q <= fifo_head_c[PAYLOAD_W-1:0];
            end
        end
    end

    // Timeline counter and run state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            if (do_halt_c) begin
                running_q <= 1'b0;
            end else if (do_run_c) begin
                running_q <= 1'b1;
            end
            if (do_clr_c) begin
                count_q <= '0;
            end else if (running_q) begin
                count_q <= count_q + TS_W'(1);
            end
        end
    end

    // Late flags; a clear on the same cycle as a late event wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            late_err_q <= 1'b0;
            late_cnt_q <= '0;
        end else if (ctrl_valid && ctrl_data[CTRL_CLR_FLAGS]) begin
            late_err_q <= 1'b0;
            late_cnt_q <= '0;
        end else if (late_evt) begin
            late_err_q <= 1'b1;
            if (late_cnt_q != '1) begin
                late_cnt_q <= late_cnt_q + LATE_CNT_W'(1);
            end
        end
    end

    assign out_tvalid = valid_q;
    assign out_tdata  = data_q;
    assign out_late   = late_q;
    assign count      = count_q;
    assign running    = running_q;
    assign late_err   = late_err_q;
    assign late_cnt   = late_cnt_q;

endmodule

// File: tb/tb_rtio_event_scheduler.sv
// Scoreboard bench for rtio_event_scheduler: stimulus pushes expected releases
// into a queue, a negedge monitor pops and compares on every output handshake.
module tb_rtio_event_scheduler;
    import rfsoc_sched_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TSW   = 64;
    localparam int unsigned PW    = 64;
    localparam int unsigned LCW   = 16;
    localparam int unsigned LVLW  = $clog2(DEPTH) + 1;

    logic              aclk;
    logic              aresetn;
    logic [TSW+PW-1:0] in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic              ctrl_valid;
    logic [3:0]        ctrl_data;
    logic [PW-1:0]     out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              out_late;
    logic [TSW-1:0]    count;
    logic              running;
    logic [LVLW-1:0]   fifo_level;
    logic              late_err;
    logic [LCW-1:0]    late_cnt;

    rtio_event_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .TS_W       (TSW),
        .PAYLOAD_W  (PW),
        .LATE_CNT_W (LCW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .ctrl_valid (ctrl_valid),
        .ctrl_data  (ctrl_data),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_late   (out_late),
        .count      (count),
        .running    (running),
        .fifo_level (fifo_level),
        .late_err   (late_err),
        .late_cnt   (late_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [PW-1:0]  payload;
        logic           late;
        bit             chk_cnt;
        logic [TSW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [PW-1:0] pl, input logic late, input bit chk,
                              input logic [TSW-1:0] cnt);
        exp_t e;
        e.payload = pl;
        e.late    = late;
        e.chk_cnt = chk;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_release", out_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_tdata", out_tdata, e.payload);
                check("out_late", 64'(out_late), 64'(e.late));
                if (e.chk_cnt) check("release_count", count, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [TSW-1:0] ts, input logic [PW-1:0] pl);
        sched_instr_t ins;
        int n;
        ins.ts    = ts;
        ins.payload = pl;
        in_tdata  = ins;
        in_tvalid = 1'b1;
        n = 0;
        while (!in_tready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("push_ready_timeout", 64'(in_tready), 64'd1);
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic send_ctrl(input logic [3:0] v);
        ctrl_data  = v;
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl_data  = 4'd0;
    endtask

    task automatic wait_count(input logic [TSW-1:0] target, input int budget);
        int n;
        n = 0;
        while (count != target && n < budget) begin
            tick();
            n++;
        end
        if (n == budget) check("wait_count_timeout", count, target);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (n == budget) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        sched_instr_t extra;
        int           n;
        logic [TSW-1:0] t0;

        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        ctrl_valid = 1'b0;
        ctrl_data  = 4'd0;
        out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;

        // Reset state: every output low.
        check("rst_in_tready", 64'(in_tready), 64'd0);
        check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_out_tdata", out_tdata, 64'd0);
        check("rst_out_late", 64'(out_late), 64'd0);
        check("rst_count", count, 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_late_err", 64'(late_err), 64'd0);
        check("rst_late_cnt", 64'(late_cnt), 64'd0);
        aresetn = 1'b1;
        tick();
        check("post_rst_in_tready", 64'(in_tready), 64'd1);

        // 1: on-time release, one cycle after count==100.
        push(64'd100, 64'hAAAA_0000_0000_0001);
        check("t1_fifo_level", 64'(fifo_level), 64'd1);
        expect_out(64'hAAAA_0000_0000_0001, 1'b0, 1'b1, 64'd101);
        send_ctrl(4'b0001);
        check("t1_running", 64'(running), 64'd1);
        wait_drain(300);

        // 2: late instruction, then clear flags.
        push(64'd5, 64'hBBBB_0000_0000_0002);
`ifndef SCHED_LATE_DROP_EN
        expect_out(64'hBBBB_0000_0000_0002, 1'b1, 1'b0, 64'd0);
`endif
        wait_drain(50);
        repeat (5) tick();
        check("t2_late_err", 64'(late_err), 64'd1);
        check("t2_late_cnt", 64'(late_cnt), 64'd1);
        send_ctrl(4'b1000);
        check("t2_late_err_clr", 64'(late_err), 64'd0);
        check("t2_late_cnt_clr", 64'(late_cnt), 64'd0);
        check("t2_still_running", 64'(running), 64'd1);

        // 3: fill while halted, back-pressure, then one pop frees a slot.
        send_ctrl(4'b0100);
        check("t3_halted", 64'(running), 64'd0);
        for (int i = 0; i < 16; i++) begin
            push(64'd0, 64'h3000 + 64'(i));
`ifndef SCHED_LATE_DROP_EN
            expect_out(64'h3000 + 64'(i), 1'b1, 1'b0, 64'd0);
`endif
        end
        check("t3_fifo_full_level", 64'(fifo_level), 64'd16);
        check("t3_in_tready_full", 64'(in_tready), 64'd0);
        extra.ts      = 64'd0;
        extra.payload = 64'h3FFF;
        in_tdata  = extra;
        in_tvalid = 1'b1;
        repeat (4) tick();
        in_tvalid = 1'b0;
        check("t3_no_overflow", 64'(fifo_level), 64'd16);
        send_ctrl(4'b0001);
        tick();
        check("t3_level_after_pop", 64'(fifo_level), 64'd15);
        check("t3_in_tready_after_pop", 64'(in_tready), 64'd1);
        wait_drain(200);
        repeat (5) tick();
        check("t3_late_cnt", 64'(late_cnt), 64'd16);
        send_ctrl(4'b1000);

        // 4: stalled release holds its payload; the next head goes out late.
        send_ctrl(4'b0100);
        send_ctrl(4'b0010);
        check("t4_count_cleared", count, 64'd0);
        push(64'd200, 64'hA4A4_0000_0000_0004);
        push(64'd205, 64'hB4B4_0000_0000_0004);
        expect_out(64'hA4A4_0000_0000_0004, 1'b0, 1'b0, 64'd0);
`ifndef SCHED_LATE_DROP_EN
        expect_out(64'hB4B4_0000_0000_0004, 1'b1, 1'b0, 64'd0);
`endif
        out_tready = 1'b0;
        send_ctrl(4'b0001);
        wait_count(64'd200, 400);
        check("t4_not_yet_valid", 64'(out_tvalid), 64'd0);
        tick();
        check("t4_valid_rise", 64'(out_tvalid), 64'd1);
        check("t4_data_rise", out_tdata, 64'hA4A4_0000_0000_0004);
        wait_count(64'd210, 50);
        check("t4_valid_held", 64'(out_tvalid), 64'd1);
        check("t4_data_held", out_tdata, 64'hA4A4_0000_0000_0004);
        out_tready = 1'b1;
        wait_drain(50);
        repeat (5) tick();
        check("t4_late_cnt", 64'(late_cnt), 64'd1);
        send_ctrl(4'b1000);

        // 5: clear counter while a far-future head waits.
        push(64'd1000, 64'hC5C5_0000_0000_0005);
        expect_out(64'hC5C5_0000_0000_0005, 1'b0, 1'b1, 64'd1001);
        wait_count(64'd300, 400);
        send_ctrl(4'b0010);
        check("t5_count_zero", count, 64'd0);
        wait_drain(1200);

        // 6: reset during ISSUE discards everything.
        out_tready = 1'b0;
        t0 = count;
        push(t0 + 64'd10, 64'hD6D6_0000_0000_0006);
        push(t0 + 64'd5000, 64'hE6E6_0000_0000_0006);
        n = 0;
        while (!out_tvalid && n < 50) begin
            tick();
            n++;
        end
        check("t6_in_issue", 64'(out_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("t6_rst_out_tdata", out_tdata, 64'd0);
        check("t6_rst_count", count, 64'd0);
        check("t6_rst_fifo_level", 64'(fifo_level), 64'd0);
        check("t6_rst_running", 64'(running), 64'd0);
        check("t6_rst_in_tready", 64'(in_tready), 64'd0);
        #3;
        aresetn = 1'b1;
        tick();
        out_tready = 1'b1;
        send_ctrl(4'b0001);
        repeat (40) tick();
        check("t6_no_stale_valid", 64'(out_tvalid), 64'd0);
        check("t6_fifo_empty", 64'(fifo_level), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
